// File: rtl/mel_lane_merger_if.sv
// mel_lane_merger_if: three mel lanes in, one ordered mel stream plus status out
interface mel_lane_merger_if #(
  parameter int I_BW  = 30,
  parameter int O_BW  = 30,
  parameter int GN_BW = 7,
  parameter int N_MEL = 80
);
  localparam int BIN_W = $clog2(N_MEL);
  logic [2:0] di_en;
  logic signed [I_BW-1:0] data_i0, data_i1, data_i2;
  logic [GN_BW-1:0] in_group_num0, in_group_num1, in_group_num2;
  logic do_en;
  logic signed [O_BW-1:0] data_o;
  logic [GN_BW-1:0] out_group_num;
  logic [BIN_W-1:0] out_bin_idx;
  logic all_done, overflow, order_err;
  modport master (
    output di_en, data_i0, data_i1, data_i2, in_group_num0, in_group_num1, in_group_num2,
    input  do_en, data_o, out_group_num, out_bin_idx, all_done, overflow, order_err
  );
  modport slave (
    input  di_en, data_i0, data_i1, data_i2, in_group_num0, in_group_num1, in_group_num2,
    output do_en, data_o, out_group_num, out_bin_idx, all_done, overflow, order_err
  );
endinterface

// File: rtl/mel_lane_merger.sv
// mel_lane_merger: buffers three mel lanes in FIFOs and releases whole frames in frame order
module mel_lane_merger #(
  parameter int I_BW       = 30,
  parameter int O_BW       = 30,
  parameter int GN_BW      = 7,
  parameter int N_MEL      = 80,
  parameter int N_FRAMES   = 89,
  parameter int FIFO_DEPTH = 128
) (
  input logic clk,
  input logic rst,
  mel_lane_merger_if.slave bus
);
  localparam int BIN_W = $clog2(N_MEL);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {WAIT, STREAM, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] sel, sel_nx;
  logic [GN_BW-1:0] frame, frame_nx;
  logic [BIN_W-1:0] bin, bin_nx;
  logic [I_BW-1:0] din [3];
  logic [GN_BW-1:0] tag [3];
  logic [I_BW-1:0] rd_data [3];
  logic [CNT_W-1:0] cnt [3];
  logic [2:0] push, pop, drop, misroute;
  assign din = '{bus.data_i0, bus.data_i1, bus.data_i2};
  assign tag = '{bus.in_group_num0, bus.in_group_num1, bus.in_group_num2};
  for (genvar i = 0; i < 3; i++) begin : g_lane
    logic [I_BW-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    assign pop[i] = state == STREAM && sel == 2'(i);
    // a same-cycle pop frees the slot, so a full FIFO still accepts the push
    assign push[i] = bus.di_en[i] && (count != CNT_W'(FIFO_DEPTH) || pop[i]);
    assign drop[i] = bus.di_en[i] && !push[i];
    assign misroute[i] = bus.di_en[i] && (tag[i] % GN_BW'(3)) != GN_BW'(i);
    assign rd_data[i] = mem[rd_ptr];
    assign cnt[i] = count;
    always_ff @(posedge clk)
      if (push[i]) mem[wr_ptr] <= din[i];
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr == PTR_W'(FIFO_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
        if (pop[i]) rd_ptr <= rd_ptr == PTR_W'(FIFO_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
        count <= count + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
  end
  always_comb begin
    state_nx = state;
    sel_nx = sel;
    frame_nx = frame;
    bin_nx = bin;
    if (state == WAIT && cnt[sel] >= CNT_W'(N_MEL)) begin
      state_nx = STREAM;
      bin_nx = '0;
    end else if (state == STREAM) begin
      bin_nx = bin + 1'b1;
      if (bin == BIN_W'(N_MEL - 1)) begin
        state_nx = frame == GN_BW'(N_FRAMES - 1) ? DONE : WAIT;
        frame_nx = frame == GN_BW'(N_FRAMES - 1) ? frame : frame + 1'b1;
        sel_nx = frame == GN_BW'(N_FRAMES - 1) ? sel : (sel == 2'd2 ? 2'd0 : sel + 1'b1);
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= WAIT;
      sel <= '0;
      frame <= '0;
      bin <= '0;
      bus.do_en <= 1'b0;
      bus.data_o <= '0;
      bus.out_group_num <= '0;
      bus.out_bin_idx <= '0;
      bus.all_done <= 1'b0;
      bus.overflow <= 1'b0;
      bus.order_err <= 1'b0;
    end else begin
      state <= state_nx;
      sel <= sel_nx;
      frame <= frame_nx;
      bin <= bin_nx;
      bus.do_en <= state == STREAM;
      if (state == STREAM) begin
        bus.data_o <= O_BW'(signed'(rd_data[sel]));
        bus.out_group_num <= frame;
        bus.out_bin_idx <= bin;
      end
      bus.all_done <= bus.all_done | (state == DONE);
      bus.overflow <= bus.overflow | (|drop);
      bus.order_err <= bus.order_err | (|misroute);
    end
endmodule

// File: doc/mel_lane_merger.md
Name: mel_lane_merger

Overview:
- Collects mel-filter results from the three parallel FFT/mel lanes and reorders them into one stream.
- Frame k is always produced by lane k%3.
- Each lane's results are buffered in a per-lane FIFO. Whole frames are released strictly in ascending frame order on a single output port.
- Sits after the three mel_filter instances and before the log stage. It also acts as the end-of-utterance controller.

Parameters:
- I_BW, 30, mel input sample width (signed)
- O_BW, 30, output sample width (signed); the input is sign-extended or truncated to fit
- GN_BW, 7, frame (group) number width
- N_MEL, 80, mel bins per frame
- N_FRAMES, 89, frames per utterance (0..88)
- FIFO_DEPTH, 128, entries per lane FIFO; must be >= N_MEL

Ports:
- clk, in, 1, system clock
- rst, in, 1, asynchronous active-high reset
- di_en, in, 3, per-lane valid; bit i belongs to lane i
- data_i0/1/2, in, I_BW each, signed mel value for lane 0/1/2
- in_group_num0/1/2, in, GN_BW each, frame number tagged on the lane's sample
- do_en, out, 1, output valid
- data_o, out, O_BW, signed mel value
- out_group_num, out, GN_BW, frame number of data_o
- out_bin_idx, out, clog2(N_MEL), bin index within the frame
- all_done, out, 1, sticky; all N_FRAMES frames have been emitted
- overflow, out, 1, sticky; a write hit a full FIFO
- order_err, out, 1, sticky; a lane wrote a frame tagged for another lane

Behaviour:
- Reset: clock and reset are as stated above. All outputs go to 0. FIFOs are emptied. Frame counter and lane pointer go to 0. The FSM enters WAIT. Reset mid-frame discards all buffered data; nothing partial is emitted afterwards.
- Write side, per lane i, every cycle with di_en[i]=1:
  - If FIFO i is not full, push data_i and in_group_num.
  - If it is full, drop the sample and set overflow.
  - If in_group_num%3 != i, set order_err; the sample is still written.
- FIFO count: a push and a pop on the same FIFO in the same cycle leave the count unchanged. A push is accepted in that cycle even when the FIFO is full.
- Scheduler FSM:
  - WAIT:
    - Selected lane = lane pointer (0/1/2).
    - When count[sel] >= N_MEL, load bin counter = 0 and go to STREAM.
    - A FIFO holding fewer than N_MEL entries is never popped.
  - STREAM:
    - Pop FIFO[sel] every cycle, N_MEL consecutive pops, no bubbles.
    - Bin counter increments on each pop.
    - On the pop with bin counter = N_MEL-1:
      - If frame counter = N_FRAMES-1, go to DONE.
      - Otherwise increment the frame counter, advance the lane pointer (2 wraps to 0), and go to WAIT.
  - DONE:
    - all_done=1 from the cycle after the last output sample until reset.
    - No further pops. Writes are still accepted into the FIFOs but never emitted.
- Output timing:
  - Registered, 1 cycle after the pop.
  - do_en=1 for exactly N_MEL consecutive cycles per frame; between frames it is at least 1 cycle low (the WAIT state).
  - out_group_num = internal frame counter, not the stored tag.
  - out_bin_idx = 0..N_MEL-1.
  - When do_en=0, data_o, out_group_num and out_bin_idx hold their last values.
- Width handling:
  - If O_BW >= I_BW, data_o is the sign-extended input.
  - Otherwise data_o is the low O_BW bits; no saturation.
- Ordering: a later frame that finishes early on another lane waits in its FIFO. It is released only after all earlier frames have been emitted.
- Simultaneous events: all three lanes may write in the same cycle, independently of the pop.

Test Plan:
- Frame 0 only: lane 0 sends 80 samples (value = bin index) tagged 0 → do_en high for 80 cycles; data_o 0..79; out_group_num=0; the first output appears 2 cycles after the 80th write.
- Out of order: lane 1 completes frame 1 before lane 0 starts frame 0 → nothing is emitted until lane 0 completes. Then frame 0 (80 cycles), a 1-cycle gap, then frame 1 (80 cycles).
- Full run: 89 frames round-robin, all lanes overlapping → 7120 outputs in frame order; all_done rises exactly after the bin-79 output of frame 88.
- Overflow: lane 2 writes 129 samples while the scheduler is waiting on lane 0 → overflow=1, 128 entries retained, order_err=0.
- Misrouted tag: lane 1 writes with in_group_num=3 → order_err=1 the next cycle and stays high.
- Reset asserted at bin 40 of frame 5 → do_en=0 immediately and all counters are 0. Restarted frame 0 input produces frame 0 output with out_group_num=0.
